// File: rtl/sobel_window_fetch.sv
// Sobel window fetcher: reads a ROWS-tall column of SRAM words per window and holds it for the consumer.
// Optional macro SOBEL_EDGE_FLAG_EN adds win_edge[1:0] (bit0: first column, bit1: last column).
module sobel_window_fetch #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned ROWS      = 4,
    parameter int unsigned COLS      = 256,
    parameter int unsigned IMG_ROWS  = 256,
    parameter int unsigned BASE_ADDR = 0,
    localparam int unsigned COL_W    = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int unsigned ROW_W    = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startEn,
    output logic                   rd_en,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic [DATA_W-1:0]      rd_data,
    output logic [ROWS*DATA_W-1:0] win_data,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic [COL_W-1:0]       win_col,
    output logic [ROW_W-1:0]       win_row,
`ifdef SOBEL_EDGE_FLAG_EN
    output logic [1:0]             win_edge,
`endif
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned IDX_W = $clog2(ROWS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(ROWS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROWS - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic                     rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
    logic [IDX_W-1:0]         rd_idx_q, rd_idx_d;
    logic                     pend_q, pend_d;
    logic [IDX_W-1:0]         pend_idx_q, pend_idx_d;
    logic [ROWS*DATA_W-1:0]   win_data_q, win_data_d;
    logic                     win_valid_q, win_valid_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
`ifdef SOBEL_EDGE_FLAG_EN
    logic [1:0]               edge_q, edge_d;
`endif

    // Word address of the bottom (newest) row of a window
    function automatic logic [ADDR_W-1:0] bottom_addr(input logic [ROW_W-1:0] r,
                                                      input logic [COL_W-1:0] c);
        return ADDR_W'(BASE_ADDR) + ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
    endfunction

    always_comb begin
        state_d     = state_q;
        rd_en_d     = rd_en_q;
        rd_addr_d   = rd_addr_q;
        rd_idx_d    = rd_idx_q;
        pend_d      = rd_en_q;
        pend_idx_d  = rd_idx_q;
        win_data_d  = win_data_q;
        win_valid_d = win_valid_q;
        col_d       = col_q;
        row_d       = row_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef SOBEL_EDGE_FLAG_EN
        edge_d      = edge_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (startEn) begin
                    state_d   = S_FETCH;
                    row_d     = ROW_FIRST;
                    col_d     = '0;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_idx_d  = '0;
                    rd_addr_d = bottom_addr(ROW_FIRST, '0);
                end
            end

            S_FETCH: begin
                // Walk upward one row per cycle until ROWS reads are out
                if (rd_en_q) begin
                    if (rd_idx_q == IDX_LAST) begin
                        rd_en_d = 1'b0;
                    end else begin
                        rd_addr_d = rd_addr_q - ADDR_W'(COLS);
                        rd_idx_d  = rd_idx_q + IDX_W'(1);
                    end
                end
                if (pend_q) begin
                    for (int k = 0; k < int'(ROWS); k++) begin
                        if (pend_idx_q == IDX_W'(k)) begin
                            win_data_d[k*DATA_W +: DATA_W] = rd_data;
                        end
                    end
                    if (pend_idx_q == IDX_LAST) begin
                        state_d     = S_HOLD;
                        win_valid_d = 1'b1;
`ifdef SOBEL_EDGE_FLAG_EN
                        edge_d      = {col_q == COL_LAST, col_q == '0};
`endif
                    end
                end
            end

            S_HOLD: begin
                if (win_ready) begin
                    win_valid_d = 1'b0;
`ifdef SOBEL_EDGE_FLAG_EN
                    edge_d      = 2'b00;
`endif
                    if (col_q != COL_LAST) begin
                        col_d   = col_q + COL_W'(1);
                        state_d = S_FETCH;
                    end else if (row_q != ROW_LAST) begin
                        col_d   = '0;
                        row_d   = row_q + ROW_W'(1);
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                    if (state_d == S_FETCH) begin
                        rd_en_d   = 1'b1;
                        rd_idx_d  = '0;
                        rd_addr_d = bottom_addr(row_d, col_d);
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_idx_q    <= '0;
            pend_q      <= 1'b0;
            pend_idx_q  <= '0;
            win_data_q  <= '0;
            win_valid_q <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SOBEL_EDGE_FLAG_EN
            edge_q      <= 2'b00;
`endif
        end else begin
            state_q     <= state_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            rd_idx_q    <= rd_idx_d;
            pend_q      <= pend_d;
            pend_idx_q  <= pend_idx_d;
            win_data_q  <= win_data_d;
            win_valid_q <= win_valid_d;
            col_q       <= col_d;
            row_q       <= row_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef SOBEL_EDGE_FLAG_EN
            edge_q      <= edge_d;
`endif
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign win_data  = win_data_q;
    assign win_valid = win_valid_q;
    assign win_col   = col_q;
    assign win_row   = row_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef SOBEL_EDGE_FLAG_EN
    assign win_edge  = edge_q;
`endif

endmodule

// File: tb/tb_sobel_window_fetch.sv
// Directed bench for sobel_window_fetch: 3-row window over a 4x4-word image, SRAM word = its address.
module tb_sobel_window_fetch;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 20;
    localparam int unsigned NR = 3;
    localparam int unsigned NC = 4;
    localparam int unsigned NI = 4;
    localparam int unsigned WW = NR * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          startEn;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [WW-1:0] win_data;
    logic          win_valid;
    logic          win_ready;
    logic [1:0]    win_col;
    logic [1:0]    win_row;
    logic          busy;
    logic          done;
`ifdef SOBEL_EDGE_FLAG_EN
    logic [1:0]    win_edge;
`endif

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int acc_cnt  = 0;

    always #5 clk = ~clk;

    sobel_window_fetch #(
        .DATA_W(DW), .ADDR_W(AW), .ROWS(NR), .COLS(NC), .IMG_ROWS(NI), .BASE_ADDR(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .startEn(startEn),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .win_data(win_data),
        .win_valid(win_valid),
        .win_ready(win_ready),
        .win_col(win_col),
        .win_row(win_row),
`ifdef SOBEL_EDGE_FLAG_EN
        .win_edge(win_edge),
`endif
        .busy(busy),
        .done(done)
    );

    // SRAM: one-cycle read latency; idle cycles return all-ones so stray captures show up
    always @(posedge clk) begin
        rd_data <= rd_en ? DW'(rd_addr) : '1;
    end

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (win_valid && win_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] exp_win(input int r, input int c);
        logic [WW-1:0] v;
        v = '0;
        for (int k = 0; k < int'(NR); k++) v[k*DW +: DW] = DW'((r - k) * int'(NC) + c);
        return v;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_win_data"}, win_data, 0);
        check({tag, "_win_valid"}, win_valid, 0);
        check({tag, "_win_col"}, win_col, 0);
        check({tag, "_win_row"}, win_row, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
`ifdef SOBEL_EDGE_FLAG_EN
        check({tag, "_win_edge"}, win_edge, 0);
`endif
    endtask

    // Called in the first FETCH cycle; returns three cycles later
    task automatic check_fetch(input int r, input int c);
        for (int k = 0; k < int'(NR); k++) begin
            check($sformatf("rd_en_r%0d_c%0d_k%0d", r, c, k), rd_en, 1);
            check($sformatf("rd_addr_r%0d_c%0d_k%0d", r, c, k), rd_addr, (r - k) * int'(NC) + c);
            check($sformatf("valid_low_r%0d_c%0d_k%0d", r, c, k), win_valid, 0);
            tick();
        end
    endtask

    task automatic wait_window();
        int n = 0;
        while (win_valid !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        check("win_valid_timeout", win_valid, 1);
    endtask

    task automatic check_window(input int r, input int c);
        logic [1:0] e;
        e = {c == int'(NC) - 1, c == 0};
        check($sformatf("win_valid_r%0d_c%0d", r, c), win_valid, 1);
        check($sformatf("win_row_r%0d_c%0d", r, c), win_row, r);
        check($sformatf("win_col_r%0d_c%0d", r, c), win_col, c);
        check($sformatf("win_data_r%0d_c%0d", r, c), win_data, exp_win(r, c));
        check($sformatf("hold_rd_en_r%0d_c%0d", r, c), rd_en, 0);
        check($sformatf("hold_busy_r%0d_c%0d", r, c), busy, 1);
`ifdef SOBEL_EDGE_FLAG_EN
        check($sformatf("win_edge_r%0d_c%0d", r, c), win_edge, e);
`else
        if (e == 2'b11) $display("unexpected edge pattern");
`endif
    endtask

    initial begin
        reset     = 1'b0;
        startEn   = 1'b0;
        win_ready = 1'b1;
        tick();
        tick();
        check_zero("reset");
        reset = 1'b1;
        tick();
        check("idle_busy", busy, 0);
        check("idle_rd_en", rd_en, 0);

        // First window, consumer stalls for five HOLD cycles
        win_ready = 1'b0;
        startEn   = 1'b1;
        tick();
        startEn   = 1'b0;
        check("start_busy", busy, 1);
        check_fetch(2, 0);
        check("no_early_valid", win_valid, 0);
        tick();
        check_window(2, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stall_valid_%0d", i), win_valid, 1);
            check($sformatf("stall_data_%0d", i), win_data, exp_win(2, 0));
            check($sformatf("stall_rd_en_%0d", i), rd_en, 0);
            check($sformatf("stall_col_%0d", i), win_col, 0);
        end
        win_ready = 1'b1;
        tick();
        check("after_stall_col", win_col, 1);

        // Remaining windows, including the row wrap and a startEn pulse while busy
        for (int w = 1; w < 8; w++) begin
            check_fetch(2 + w / 4, w % 4);
            wait_window();
            check_window(2 + w / 4, w % 4);
            if (w == 5) startEn = 1'b1;
            tick();
            startEn = 1'b0;
        end
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_rd_en", rd_en, 0);
        check("done_valid", win_valid, 0);
        tick();
        check("post_done", done, 0);
        check("post_busy", busy, 0);
        tick();
        tick();
        tick();
        check("done_count", done_cnt, 1);
        check("window_count", acc_cnt, 8);

        // Abandon a frame during the col=2 fetch, then restart cleanly
        startEn = 1'b1;
        tick();
        startEn = 1'b0;
        check_fetch(2, 0);
        wait_window();
        check_window(2, 0);
        tick();
        check_fetch(2, 1);
        wait_window();
        check_window(2, 1);
        tick();
        check("mid_rd_addr", rd_addr, 10);
        tick();
        reset = 1'b0;
        #1;
        check_zero("midreset");
        tick();
        reset = 1'b1;
        tick();
        check("restart_idle_rd_en", rd_en, 0);
        check("restart_idle_busy", busy, 0);
        startEn = 1'b1;
        tick();
        startEn = 1'b0;
        check_fetch(2, 0);
        wait_window();
        check_window(2, 0);
        tick();
        tick();
        check("no_stale_done", done_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
